// File: rtl/prog_fsm_pkg.sv
// rtl/prog_fsm_pkg.sv - shared defaults and table indexing for the programmable Moore FSM
package prog_fsm_pkg;

    localparam int DEF_STATE_W     = 3;
    localparam int DEF_IN_W        = 2;
    localparam int DEF_OUT_W       = 4;
    localparam int DEF_RESET_STATE = 0;
    localparam int DEF_CNT_W       = 16;

    // Flat next-state table index: one row of 2**in_w entries per state.
    function automatic int tbl_idx(input int s, input int v, input int in_w);
        return s * (1 << in_w) + v;
    endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// rtl/prog_fsm_table.sv - next-state register file, one write port, one combinational read port
module prog_fsm_table
    import prog_fsm_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int IN_W    = DEF_IN_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_we,
    input  logic [STATE_W-1:0] i_wr_state,
    input  logic [IN_W-1:0]    i_wr_in,
    input  logic [STATE_W-1:0] i_wr_next,
    input  logic [STATE_W-1:0] i_rd_state,
    input  logic [IN_W-1:0]    i_rd_in,
    output logic [STATE_W-1:0] o_rd_next
);

    localparam int IDX_W   = STATE_W + IN_W;
    localparam int ENTRIES = 1 << IDX_W;

    logic [STATE_W-1:0] nt [ENTRIES];
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;

    assign wr_idx = IDX_W'(tbl_idx(int'(i_wr_state), int'(i_wr_in), IN_W));
    assign rd_idx = IDX_W'(tbl_idx(int'(i_rd_state), int'(i_rd_in), IN_W));

    // Reset pattern makes every state a self-loop so an unprogrammed FSM never moves.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                nt[IDX_W'(i)] <= STATE_W'(i >> IN_W);
            end
        end else if (i_we) begin
            nt[wr_idx] <= i_wr_next;
        end
    end

    assign o_rd_next = nt[rd_idx];

endmodule

// File: rtl/prog_moore_fsm.sv
// rtl/prog_moore_fsm.sv - run-time programmable Moore FSM top
// Optional transition counter enabled by defining PROG_FSM_TRACE_EN.
module prog_moore_fsm
    import prog_fsm_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int IN_W        = DEF_IN_W,
    parameter int OUT_W       = DEF_OUT_W,
    parameter int RESET_STATE = DEF_RESET_STATE
`ifdef PROG_FSM_TRACE_EN
    ,
    parameter int CNT_W       = DEF_CNT_W
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_restart,
    input  logic [IN_W-1:0]    i_in,
    input  logic               i_nxt_we,
    input  logic               i_out_we,
    input  logic [STATE_W-1:0] i_cfg_state,
    input  logic [IN_W-1:0]    i_cfg_in,
    input  logic [STATE_W-1:0] i_cfg_next,
    input  logic [OUT_W-1:0]   i_cfg_out,
    output logic [STATE_W-1:0] o_state,
    output logic [OUT_W-1:0]   o_z,
    output logic               o_changed
`ifdef PROG_FSM_TRACE_EN
    ,
    output logic [CNT_W-1:0]   o_trans_cnt
`endif
);

    localparam int                 NUM_STATES = 1 << STATE_W;
    localparam logic [STATE_W-1:0] RST_ST     = STATE_W'(RESET_STATE);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] next_state;
    logic [STATE_W-1:0] nt_next;
    logic [OUT_W-1:0]   ot [NUM_STATES];
    logic [OUT_W-1:0]   z_q;
    logic [OUT_W-1:0]   z_next;
    logic               changed_q;

    prog_fsm_table #(
        .STATE_W (STATE_W),
        .IN_W    (IN_W)
    ) u_table (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_we       (i_nxt_we),
        .i_wr_state (i_cfg_state),
        .i_wr_in    (i_cfg_in),
        .i_wr_next  (i_cfg_next),
        .i_rd_state (state_q),
        .i_rd_in    (i_in),
        .o_rd_next  (nt_next)
    );

    always_comb begin
        next_state = state_q;
        if (i_restart) begin
            next_state = RST_ST;
        end else if (i_en) begin
            next_state = nt_next;
        end
    end

    // Bypass a same-cycle output write so o_z always matches OT of the state being entered.
    always_comb begin
        z_next = ot[next_state];
        if (i_out_we && (i_cfg_state == next_state)) begin
            z_next = i_cfg_out;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RST_ST;
            z_q       <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                ot[STATE_W'(i)] <= '0;
            end
        end else begin
            state_q   <= next_state;
            z_q       <= z_next;
            changed_q <= (next_state != state_q);
            if (i_out_we) begin
                ot[i_cfg_state] <= i_cfg_out;
            end
        end
    end

    assign o_state   = state_q;
    assign o_z       = z_q;
    assign o_changed = changed_q;

`ifdef PROG_FSM_TRACE_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if ((next_state != state_q) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_trans_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_prog_moore_fsm.sv
// tb/tb_prog_moore_fsm.sv - scoreboard bench for prog_moore_fsm (PROG_FSM_TRACE_EN optional)
module tb_prog_moore_fsm;

    localparam int STATE_W = 3;
    localparam int IN_W    = 2;
    localparam int OUT_W   = 4;
    localparam int CNT_MAX = 7;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic               i_en = 1'b0;
    logic               i_restart = 1'b0;
    logic [IN_W-1:0]    i_in = '0;
    logic               i_nxt_we = 1'b0;
    logic               i_out_we = 1'b0;
    logic [STATE_W-1:0] i_cfg_state = '0;
    logic [IN_W-1:0]    i_cfg_in = '0;
    logic [STATE_W-1:0] i_cfg_next = '0;
    logic [OUT_W-1:0]   i_cfg_out = '0;
    logic [STATE_W-1:0] o_state;
    logic [OUT_W-1:0]   o_z;
    logic               o_changed;
`ifdef PROG_FSM_TRACE_EN
    logic [2:0]         o_trans_cnt;
`endif

    prog_moore_fsm #(
        .STATE_W     (STATE_W),
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .RESET_STATE (0)
`ifdef PROG_FSM_TRACE_EN
        ,
        .CNT_W       (3)
`endif
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_en),
        .i_restart   (i_restart),
        .i_in        (i_in),
        .i_nxt_we    (i_nxt_we),
        .i_out_we    (i_out_we),
        .i_cfg_state (i_cfg_state),
        .i_cfg_in    (i_cfg_in),
        .i_cfg_next  (i_cfg_next),
        .i_cfg_out   (i_cfg_out),
        .o_state     (o_state),
        .o_z         (o_z),
        .o_changed   (o_changed)
`ifdef PROG_FSM_TRACE_EN
        ,
        .o_trans_cnt (o_trans_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [2:0] s;
        logic [3:0] z;
        logic       c;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents a new output every edge; compare against the oldest expectation.
    always @(posedge i_clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("state", int'(o_state), int'(mon_e.s));
            check("z", int'(o_z), int'(mon_e.z));
            check("changed", int'(o_changed), int'(mon_e.c));
`ifdef PROG_FSM_TRACE_EN
            check("trans_cnt", int'(o_trans_cnt), int'(mon_e.cnt));
`endif
        end
    end

    task automatic wr_nxt(input int s, input int v, input int n);
        i_nxt_we    = 1'b1;
        i_cfg_state = 3'(s);
        i_cfg_in    = 2'(v);
        i_cfg_next  = 3'(n);
    endtask

    task automatic wr_out(input int s, input int o);
        i_out_we    = 1'b1;
        i_cfg_state = 3'(s);
        i_cfg_out   = 4'(o);
    endtask

    task automatic step(input int en, input int restart, input int in,
                        input int es, input int ez, input int ec);
        @(negedge i_clk);
        i_en      = 1'(en);
        i_restart = 1'(restart);
        i_in      = 2'(in);
        if (ec != 0 && exp_cnt < CNT_MAX) exp_cnt++;
        q.push_back(exp_t'{s: 3'(es), z: 4'(ez), c: 1'(ec), cnt: 8'(exp_cnt)});
        @(posedge i_clk);
        #2;
        i_nxt_we  = 1'b0;
        i_out_we  = 1'b0;
        i_restart = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_state", int'(o_state), 0);
        check("rst_z", int'(o_z), 0);
        check("rst_changed", int'(o_changed), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 10; i++) step(1, 0, int'($urandom_range(0, 3)), 0, 0, 0);

        // chain: NT[s][1] = s+1 mod 8, OT[s] = s
        for (int s = 0; s < 8; s++) begin
            wr_nxt(s, 1, (s + 1) % 8);
            wr_out(s, s);
            step(0, 0, 0, 0, 0, 0);
        end

        for (int k = 1; k <= 8; k++) step(1, 0, 1, k % 8, k % 8, 1);
        step(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) step(1, 0, 1, k, k, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4, 4, 0);
        step(1, 0, 1, 5, 5, 1);
        step(1, 1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0);

        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 2, 2, 1);
        wr_nxt(2, 1, 6);
        step(1, 0, 1, 3, 3, 1);
        wr_out(3, 10);
        step(0, 0, 0, 3, 10, 0);
        for (int k = 4; k < 11; k++) step(1, 0, 1, k % 8, k % 8, 1);
        step(1, 0, 1, 6, 6, 1);
        wr_out(7, 5);
        step(1, 0, 1, 7, 5, 1);
        step(1, 0, 1, 0, 0, 1);
        step(1, 0, 1, 1, 1, 1);
        step(1, 0, 1, 2, 2, 1);
        step(1, 0, 1, 6, 6, 1);

        #1;
        i_rst_n = 1'b0;
        #1;
        check("async_rst_state", int'(o_state), 0);
        check("async_rst_z", int'(o_z), 0);
        check("async_rst_changed", int'(o_changed), 0);
`ifdef PROG_FSM_TRACE_EN
        check("async_rst_cnt", int'(o_trans_cnt), 0);
`endif
        exp_cnt = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        wr_out(0, 3);
        step(0, 0, 0, 0, 3, 0);

        repeat (3) @(posedge i_clk);
        check("queue_drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/prog_moore_fsm.md
# prog_moore_fsm

Parametrised, run-time programmable Moore state machine. Next-state and output tables live in on-block registers and are loaded through a write port, so the same RTL implements any lab-style Moore controller without re-synthesis. The block sits between the lab I/O (switches as inputs, LEDs/7-seg as outputs) and replaces hard-coded single-purpose FSMs.

## Interface
- STATE_W, 3: state register width; NUM_STATES = 2**STATE_W
- IN_W, 2: input vector width; each state has 2**IN_W transition entries
- OUT_W, 4: Moore output width per state
- RESET_STATE, 0: state entered on reset and on soft restart
- CNT_W, 16: transition counter width (only with PROG_FSM_TRACE_EN)

- i_clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  1 = evaluate transition this cycle; 0 = hold state
- i_restart  in  1  synchronous return to RESET_STATE
- i_in  in  IN_W  FSM input vector
- i_nxt_we  in  1  write one next-state entry
- i_out_we  in  1  write one output entry
- i_cfg_state  in  STATE_W  entry state address (both tables)
- i_cfg_in  in  IN_W  entry input address (next-state table only)
- i_cfg_next  in  STATE_W  next-state write data
- i_cfg_out  in  OUT_W  output write data
- o_state  out  STATE_W  current state
- o_z  out  OUT_W  registered Moore output
- o_changed  out  1  one-cycle pulse: o_state changed on the last edge
- o_trans_cnt  out  CNT_W  transition count (only with PROG_FSM_TRACE_EN)

## Operation
- Next-state table NT[s][v], NUM_STATES x 2**IN_W entries of STATE_W; output table OT[s], NUM_STATES entries of OUT_W.
- Reset (i_rst_n low, immediate): o_state = RESET_STATE, o_z = 0, o_changed = 0, o_trans_cnt = 0, NT[s][v] = s (self-loop everywhere), OT[s] = 0.
- Per edge, priority: i_restart > i_en > hold.
  - i_restart = 1: next = RESET_STATE, regardless of i_en.
  - else i_en = 1: next = NT[o_state][i_in], read from pre-write contents.
  - else: next = o_state.
- o_changed = (next != o_state) registered; restart while already in RESET_STATE gives no pulse.
- Table writes: i_nxt_we writes NT[i_cfg_state][i_cfg_in] = i_cfg_next; i_out_we writes OT[i_cfg_state] = i_cfg_out; both may occur in one cycle; writes take effect at the edge.
- o_z <= OT'[next], where OT' is the table including this cycle's i_out_we write (write bypass). Thus o_z always equals OT[o_state].
- Writes are legal while running; no stall, no busy flag.

## Timing
- Input to o_state: 1 cycle. o_z and o_changed aligned with o_state (same edge).
- Output table write to a state then occupied: o_z reflects new value on the edge after the write.
- Next-state write to the entry used in the same cycle: old value used for that transition; new value from the next evaluation.
- Reset mid-operation: all tables and outputs return to reset values asynchronously; programming is lost.

## Configuration
- PROG_FSM_TRACE_EN defined: o_trans_cnt increments on each edge where o_changed is set, saturates at all-ones, cleared only by i_rst_n (not by i_restart).
- Not defined: o_trans_cnt port and counter absent; all other behaviour identical.

## Structure
- Package prog_fsm_pkg: default parameter constants, function for table index (s * 2**IN_W + v).
- One sub-module, prog_fsm_table: NT register file with write port and combinational read port, reset to self-loop pattern. OT, state register and counter stay in the top.

## Test plan
- Reset with defaults -> o_state = 0, o_z = 0, o_changed = 0; 10 cycles i_en = 1 with any i_in -> o_state stays 0 (self-loop), no o_changed.
- Program 8-state chain NT[s][1] = s+1 mod 8, OT[s] = s; drive i_in = 1, i_en = 1 -> o_state 1,2,...,7,0, o_z tracks o_state, o_changed every cycle.
- Same program, i_en = 0 for 3 cycles mid-chain at state 4 -> state/o_z hold at 4; i_restart = 1 with i_en = 1 at state 5 -> o_state = 0, o_z = OT[0].
- At state 2 write NT[2][1] = 6 in the transition cycle -> goes to 3; returning to 2 later -> goes to 6. Write OT[3] = 4'hA while in 3 -> o_z = 4'hA next edge.
- Assert i_rst_n low mid-run at state 6 -> o_state = 0, o_z = 0 immediately, tables back to self-loop.
- With PROG_FSM_TRACE_EN, CNT_W = 3: 9 transitions -> o_trans_cnt = 7 (saturated); i_restart does not clear it.
